note_word_classifier: RTL and testbench
=======================================

NOTE_WORD_CLASSIFIER -- requirements
Module: note_word_classifier

Interface
REQ-001 SHALL have parameter ROOT_LEN, 2, number of root notes before the suffix (1..7).
REQ-002 SHALL have parameter SUF_LEN, 2, maximum suffix length in tokens (1..4).
REQ-003 SHALL have parameter NUM_SUF, 8, number of suffix-table entries (1..16).
REQ-004 SHALL have parameter CLASS_W, 2, width of the class code.
REQ-005 SHALL have parameter TIMEOUT, 0, idle cycles allowed mid-word before error; 0 disables the timeout.
REQ-006 SHALL have port clk  in  1  the single clock.
REQ-007 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port ok  in  1  token strobe; one token is consumed per clk edge with ok=1.
REQ-009 SHALL have port tom  in  1  accidental (sharp) flag of the token.
REQ-010 SHALL have port nota  in  3  note code; 000 = terminator, 001..111 = do..si.
REQ-011 SHALL have port cfg_we  in  1  suffix-table write strobe.
REQ-012 SHALL have port cfg_idx  in  $clog2(NUM_SUF)  entry index to write.
REQ-013 SHALL have port cfg_data  in  1+4*SUF_LEN+3+CLASS_W  packed entry: {enable, tokens[SUF_LEN-1:0] as {tom,nota}, len, class}.
REQ-014 SHALL have port fim  out  1  high while in DONE or ERROR.
REQ-015 SHALL have port tipo  out  CLASS_W  class of the recognised word; 0 when not in DONE.
REQ-016 SHALL have port done  out  1  one-cycle pulse on entry to DONE or ERROR.
REQ-017 SHALL have port err  out  1  high while in ERROR.
REQ-018 SHALL have port word_cnt  out  8  count of words reaching DONE, wrapping at 255 -> 0.

Function
REQ-019 SHALL implement the states IDLE, ROOT, SUFFIX, DONE and ERROR; token acceptance occurs only on edges where ok=1.
REQ-020 IDLE, DONE, ERROR: on ok with nota!=000, SHALL count the note as root note 1 and go to ROOT, or to SUFFIX when ROOT_LEN=1; on ok with nota=000 SHALL go to ERROR.
REQ-021 ROOT: on ok with nota!=000, SHALL increment the root count and go to SUFFIX once ROOT_LEN notes have been taken; on nota=000 SHALL go to ERROR.
REQ-022 On entry to SUFFIX, SHALL load the candidate mask with the enable bits of all entries and set position p=0.
REQ-023 SUFFIX, ok with nota!=000: entry i SHALL survive iff it is a candidate, p<len_i, and token[p]_i equals {tom,nota}; p SHALL increment.
REQ-024 SUFFIX: if the new mask is zero, or p would exceed SUF_LEN, SHALL go to ERROR.
REQ-025 SUFFIX, ok with nota=000: SHALL select the lowest-index candidate with len_i==p, go to DONE and latch its class into tipo; if there is none, SHALL go to ERROR.
REQ-026 A len_i of 0 SHALL match an empty suffix, i.e. a terminator directly after the root.
REQ-027 In DONE and ERROR the state SHALL be held without ok; a following token SHALL start a new word per REQ-020 in the same edge.
REQ-028 The idle counter SHALL clear on every ok and count otherwise while in ROOT or SUFFIX; when TIMEOUT>0 and the counter reaches TIMEOUT, SHALL go to ERROR.
REQ-029 cfg_we SHALL write the entry on the edge; a write during SUFFIX SHALL NOT alter the current candidate mask, and the new entry SHALL apply from the next word.
REQ-030 word_cnt SHALL increment on the edge entering DONE; done SHALL be registered, so it is high the cycle after that edge.
REQ-031 Latency SHALL be one clk: fim, tipo and err reflect the terminator on the cycle after it is accepted.

Reset
REQ-032 reset=0 SHALL asynchronously force: state IDLE; fim=0, tipo=0, done=0, err=0, word_cnt=0; counters and mask cleared.
REQ-033 Reset SHALL clear all table enable bits; table contents SHALL be loaded via cfg before use.
REQ-034 Reset asserted mid-word SHALL abandon the word with no done pulse.

Structure
REQ-035 The shared package SHALL hold the note codes (nota_x..si), the state enum, the class codes (nulo=0, adj=1, comp=2, adv=3) and the entry-field offset function.
REQ-036 The design SHALL contain one sub-module, suffix_match, combinational: inputs mask, table, p, token; outputs next mask and the lowest matching-length index with a valid flag.

Verification
Table for all scenarios: e0={la}/1/adj, e1={si}/1/adj, e2={la,#do}/2/comp, e3={si,#re}/2/comp, e4={la,si}/2/adv.
REQ-037 Tokens do,mi,la,000 -> fim=1, tipo=01, done pulse, word_cnt=1.
REQ-038 Tokens re,fa,si,#re,000 -> tipo=10; then fa,sol,la,si,000 -> tipo=11, word_cnt=2 (back-to-back, no idle).
REQ-039 Tokens do,re,#la -> ERROR, err=1, tipo=00; a 000 as the first token -> ERROR.
REQ-040 Tokens do,re,la,si,si -> ERROR (p exceeds SUF_LEN); TIMEOUT=5 with do then 5 idle cycles -> ERROR.
REQ-041 reset=0 pulsed between edges after do,re -> immediate IDLE, no done; entry e0 rewritten to comp mid-word -> current word still adj, next word comp.

Source files
------------

// File: rtl/note_word_classifier_pkg.sv
// note_word_classifier_pkg
// Shared definitions for the note-word classifier: note codes, FSM state
// encoding, class codes and the bit offsets of fields inside a packed
// suffix-table entry {enable, tokens[SUF_LEN-1:0] as {tom,nota}, len, class}.
package note_word_classifier_pkg;

  localparam logic [2:0] nota_x   = 3'd0;  // word terminator
  localparam logic [2:0] nota_do  = 3'd1;
  localparam logic [2:0] nota_re  = 3'd2;
  localparam logic [2:0] nota_mi  = 3'd3;
  localparam logic [2:0] nota_fa  = 3'd4;
  localparam logic [2:0] nota_sol = 3'd5;
  localparam logic [2:0] nota_la  = 3'd6;
  localparam logic [2:0] nota_si  = 3'd7;

  typedef enum logic [2:0] {IDLE, ROOT, SUFFIX, DONE, ERROR} state_t;

  localparam int unsigned nulo = 0;
  localparam int unsigned adj  = 1;
  localparam int unsigned comp = 2;
  localparam int unsigned adv  = 3;

  typedef enum logic [1:0] {F_CLASS, F_LEN, F_TOK, F_EN} field_t;

  // LSB position of a field within one entry; k selects the suffix token.
  function automatic int unsigned field_off(field_t f, int unsigned class_w,
                                            int unsigned suf_len, int unsigned k);
    case (f)
      F_CLASS: return 0;
      F_LEN:   return class_w;
      F_TOK:   return class_w + 3 + 4 * k;
      default: return class_w + 3 + 4 * suf_len;
    endcase
  endfunction

endpackage

// File: rtl/note_word_classifier_suffix_match.sv
// suffix_match
// Combinational suffix matcher. Filters the candidate mask against the
// token at suffix position p and reports the lowest-index candidate whose
// length equals p (the entry a terminator at this point would select).
// Ports:
//   mask      - current candidate set
//   tbl       - packed suffix table, entry i at [i*EW +: EW]
//   p         - number of suffix tokens already consumed
//   token     - incoming {tom, nota}
//   next_mask - candidates still alive after this token
//   hit_idx   - lowest candidate index with len == p
//   hit_valid - hit_idx is meaningful
module suffix_match
  import note_word_classifier_pkg::*;
#(
  parameter int unsigned NUM_SUF = 8,
  parameter int unsigned SUF_LEN = 2,
  parameter int unsigned CLASS_W = 2,
  localparam int unsigned EW = 1 + 4 * SUF_LEN + 3 + CLASS_W,
  localparam int unsigned IW = (NUM_SUF > 1) ? $clog2(NUM_SUF) : 1
) (
  input  logic [NUM_SUF-1:0]    mask,
  input  logic [NUM_SUF*EW-1:0] tbl,
  input  logic [2:0]            p,
  input  logic [3:0]            token,
  output logic [NUM_SUF-1:0]    next_mask,
  output logic [IW-1:0]         hit_idx,
  output logic                  hit_valid
);

  localparam int unsigned LEN_OFF = field_off(F_LEN, CLASS_W, SUF_LEN, 0);
  localparam int unsigned EN_OFF  = field_off(F_EN, CLASS_W, SUF_LEN, 0);

  logic [2:0] len_i;
  logic [3:0] tok_p;
  logic       tok_ok;
  logic       unused_class;  // class fields are resolved by the parent

  always_comb begin
    next_mask    = '0;
    hit_idx      = '0;
    hit_valid    = 1'b0;
    len_i        = '0;
    tok_p        = '0;
    tok_ok       = 1'b0;
    unused_class = 1'b0;
    for (int unsigned i = 0; i < NUM_SUF; i++) begin
      len_i  = tbl[i*EW + LEN_OFF +: 3];
      tok_p  = '0;
      tok_ok = 1'b0;
      // p may equal SUF_LEN; there is no token slot there, so nothing survives
      for (int unsigned k = 0; k < SUF_LEN; k++) begin
        if (32'(p) == k) begin
          tok_p  = tbl[i*EW + field_off(F_TOK, CLASS_W, SUF_LEN, k) +: 4];
          tok_ok = 1'b1;
        end
      end
      next_mask[i] = mask[i] && tbl[i*EW + EN_OFF] && tok_ok &&
                     (p < len_i) && (tok_p == token);
      if (!hit_valid && mask[i] && (len_i == p)) begin
        hit_valid = 1'b1;
        hit_idx   = IW'(i);
      end
      unused_class = unused_class ^ (^tbl[i*EW +: CLASS_W]);
    end
  end

endmodule

// File: rtl/note_word_classifier.sv
// note_word_classifier
// Token-stream word classifier: ROOT_LEN root notes followed by a suffix of
// up to SUF_LEN {tom,nota} tokens and a terminator. The suffix is matched
// against a programmable table; the class of the lowest-index exact match
// is reported one cycle after the terminator.
// Ports:
//   clk, reset (async, active low)
//   ok, tom, nota       - token strobe and token
//   cfg_we/idx/data     - suffix-table write port
//   fim                 - high in DONE or ERROR
//   tipo                - recognised class (0 outside DONE)
//   done                - one-cycle pulse after entering DONE/ERROR
//   err                 - high in ERROR
//   word_cnt            - words recognised, wraps at 255
module note_word_classifier
  import note_word_classifier_pkg::*;
#(
  parameter int unsigned ROOT_LEN = 2,
  parameter int unsigned SUF_LEN  = 2,
  parameter int unsigned NUM_SUF  = 8,
  parameter int unsigned CLASS_W  = 2,
  parameter int unsigned TIMEOUT  = 0,
  localparam int unsigned IW = (NUM_SUF > 1) ? $clog2(NUM_SUF) : 1,
  localparam int unsigned EW = 1 + 4 * SUF_LEN + 3 + CLASS_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ok,
  input  logic               tom,
  input  logic [2:0]         nota,
  input  logic               cfg_we,
  input  logic [IW-1:0]      cfg_idx,
  input  logic [EW-1:0]      cfg_data,
  output logic               fim,
  output logic [CLASS_W-1:0] tipo,
  output logic               done,
  output logic               err,
  output logic [7:0]         word_cnt
);

  localparam int unsigned TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned EN_OFF = field_off(F_EN, CLASS_W, SUF_LEN, 0);

  state_t                state, state_n;
  logic [2:0]            root_cnt, root_n, p, p_n;
  logic [NUM_SUF-1:0]    mask, mask_n, en_all, match_mask;
  logic [NUM_SUF*EW-1:0] tbl_cfg, tbl_act;
  logic [TW-1:0]         idle_cnt, idle_n;
  logic [CLASS_W-1:0]    cls_q, cls_n;
  logic [IW-1:0]         hit_idx;
  logic                  hit_valid, load_act, to_done, to_err, timed_out;

  // Matching runs on a snapshot taken on entry to SUFFIX, so cfg writes
  // during a suffix only become visible to the next word.
  suffix_match #(
    .NUM_SUF(NUM_SUF),
    .SUF_LEN(SUF_LEN),
    .CLASS_W(CLASS_W)
  ) u_match (
    .mask     (mask),
    .tbl      (tbl_act),
    .p        (p),
    .token    ({tom, nota}),
    .next_mask(match_mask),
    .hit_idx  (hit_idx),
    .hit_valid(hit_valid)
  );

  always_comb begin
    en_all = '0;
    for (int unsigned i = 0; i < NUM_SUF; i++) en_all[i] = tbl_cfg[i*EW + EN_OFF];
  end

  // Fires on the idle edge that brings the counter up to TIMEOUT.
  assign timed_out = (TIMEOUT > 0) && !ok && ((32'(idle_cnt) + 32'd1) == TIMEOUT);

  always_comb begin
    state_n  = state;
    root_n   = root_cnt;
    p_n      = p;
    mask_n   = mask;
    cls_n    = cls_q;
    idle_n   = '0;
    load_act = 1'b0;
    to_done  = 1'b0;
    to_err   = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (ok) begin
          if (nota != nota_x) begin
            root_n = 3'd1;
            if (ROOT_LEN == 1) load_act = 1'b1;
            else               state_n  = ROOT;
          end else begin
            to_err = 1'b1;
          end
        end
      end
      ROOT: begin
        if (ok) begin
          if (nota != nota_x) begin
            root_n = root_cnt + 3'd1;
            if (root_n == 3'(ROOT_LEN)) load_act = 1'b1;
          end else begin
            to_err = 1'b1;
          end
        end else if (timed_out) begin
          to_err = 1'b1;
        end else begin
          idle_n = idle_cnt + TW'(1);
        end
      end
      SUFFIX: begin
        if (ok) begin
          if (nota != nota_x) begin
            if ((32'(p) >= SUF_LEN) || (match_mask == '0)) begin
              to_err = 1'b1;
            end else begin
              mask_n = match_mask;
              p_n    = p + 3'd1;
            end
          end else if (hit_valid) begin
            to_done = 1'b1;
            cls_n   = tbl_act[hit_idx*EW +: CLASS_W];
          end else begin
            to_err = 1'b1;
          end
        end else if (timed_out) begin
          to_err = 1'b1;
        end else begin
          idle_n = idle_cnt + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (load_act) begin
      state_n = SUFFIX;
      mask_n  = en_all;
      p_n     = '0;
    end
    if (to_done) state_n = DONE;
    if (to_err)  state_n = ERROR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      root_cnt <= '0;
      p        <= '0;
      mask     <= '0;
      idle_cnt <= '0;
      cls_q    <= '0;
      done     <= 1'b0;
      word_cnt <= '0;
      tbl_cfg  <= '0;
      tbl_act  <= '0;
    end else begin
      state    <= state_n;
      root_cnt <= root_n;
      p        <= p_n;
      mask     <= mask_n;
      idle_cnt <= idle_n;
      cls_q    <= cls_n;
      done     <= to_done | to_err;
      if (to_done)  word_cnt <= word_cnt + 8'd1;
      if (load_act) tbl_act <= tbl_cfg;
      if (cfg_we)   tbl_cfg[cfg_idx*EW +: EW] <= cfg_data;
    end
  end

  assign fim  = (state == DONE) || (state == ERROR);
  assign err  = (state == ERROR);
  assign tipo = (state == DONE) ? cls_q : '0;

endmodule

// File: tb/tb_note_word_classifier.sv
module tb_note_word_classifier;
  import note_word_classifier_pkg::*;

  logic        clk = 1'b0;
  logic        reset, ok, tom, cfg_we;
  logic [2:0]  nota, cfg_idx;
  logic [13:0] cfg_data;
  logic        fim, done, err, fim_t, done_t, err_t;
  logic [1:0]  tipo, tipo_t;
  logic [7:0]  word_cnt, word_cnt_t;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  note_word_classifier dut (
    .clk(clk), .reset(reset), .ok(ok), .tom(tom), .nota(nota),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .fim(fim), .tipo(tipo), .done(done), .err(err), .word_cnt(word_cnt)
  );

  note_word_classifier #(.TIMEOUT(5)) dut_to (
    .clk(clk), .reset(reset), .ok(ok), .tom(tom), .nota(nota),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .fim(fim_t), .tipo(tipo_t), .done(done_t), .err(err_t), .word_cnt(word_cnt_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [13:0] entry(input logic en, input logic [3:0] t1,
                                        input logic [3:0] t0, input logic [2:0] len,
                                        input logic [1:0] cls);
    return {en, t1, t0, len, cls};
  endfunction

  task automatic send(input logic t, input logic [2:0] n);
    tom = t; nota = n; ok = 1'b1;
    @(posedge clk); #1;
    ok = 1'b0; tom = 1'b0; nota = nota_x;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [13:0] data);
    cfg_we = 1'b1; cfg_idx = idx; cfg_data = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic program_table();
    cfg(3'd0, entry(1'b1, 4'h0, {1'b0, nota_la}, 3'd1, 2'(adj)));
    cfg(3'd1, entry(1'b1, 4'h0, {1'b0, nota_si}, 3'd1, 2'(adj)));
    cfg(3'd2, entry(1'b1, {1'b1, nota_do}, {1'b0, nota_la}, 3'd2, 2'(comp)));
    cfg(3'd3, entry(1'b1, {1'b1, nota_re}, {1'b0, nota_si}, 3'd2, 2'(comp)));
    cfg(3'd4, entry(1'b1, {1'b0, nota_si}, {1'b0, nota_la}, 3'd2, 2'(adv)));
    // empty suffix: terminator straight after the root
    cfg(3'd5, entry(1'b1, 4'h0, 4'h0, 3'd0, 2'(adj)));
  endtask

  task automatic pulse_reset();
    reset = 1'b0; #4; reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; ok = 1'b0; tom = 1'b0; nota = nota_x;
    cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
    #12 reset = 1'b1;
    @(posedge clk); #1;

    check("rst_fim", fim, 0);
    check("rst_tipo", tipo, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_wcnt", word_cnt, 0);
    check("rst_err_to", err_t, 0);

    // terminator as the very first token
    send(1'b0, nota_x);
    check("first_x_err", err, 1);
    check("first_x_done", done, 1);
    check("first_x_tipo", tipo, 0);

    program_table();
    check("done_drop", done, 0);

    // do mi la . -> adj
    send(0, nota_do); send(0, nota_mi); send(0, nota_la); send(0, nota_x);
    check("adj_fim", fim, 1);
    check("adj_tipo", tipo, 1);
    check("adj_done", done, 1);
    check("adj_err", err, 0);
    check("adj_wcnt", word_cnt, 1);
    idle(1);
    check("adj_done_1cyc", done, 0);
    check("adj_tipo_hold", tipo, 1);

    // re fa si #re . -> comp, then back-to-back fa sol la si . -> adv
    send(0, nota_re); send(0, nota_fa); send(0, nota_si); send(1, nota_re); send(0, nota_x);
    check("comp_tipo", tipo, 2);
    check("comp_wcnt", word_cnt, 2);
    send(0, nota_fa);
    check("b2b_fim", fim, 0);
    check("b2b_tipo", tipo, 0);
    send(0, nota_sol); send(0, nota_la); send(0, nota_si); send(0, nota_x);
    check("adv_tipo", tipo, 3);
    check("adv_done", done, 1);
    check("adv_wcnt", word_cnt, 3);

    // empty suffix
    send(0, nota_do); send(0, nota_re); send(0, nota_x);
    check("len0_tipo", tipo, 1);
    check("len0_err", err, 0);
    check("len0_wcnt", word_cnt, 4);

    // unknown suffix token
    send(0, nota_do); send(0, nota_re); send(1, nota_la);
    check("nomatch_err", err, 1);
    check("nomatch_tipo", tipo, 0);
    check("nomatch_done", done, 1);
    check("nomatch_wcnt", word_cnt, 4);

    // suffix longer than SUF_LEN
    send(0, nota_do); send(0, nota_re); send(0, nota_la); send(0, nota_si);
    check("long_pre_err", err, 0);
    send(0, nota_si);
    check("long_err", err, 1);

    // table rewrite mid-suffix applies only from the next word
    send(0, nota_do); send(0, nota_re); send(0, nota_la);
    cfg(3'd0, entry(1'b1, 4'h0, {1'b0, nota_la}, 3'd1, 2'(comp)));
    send(0, nota_x);
    check("rewr_cur_tipo", tipo, 1);
    check("rewr_wcnt", word_cnt, 5);
    send(0, nota_do); send(0, nota_re); send(0, nota_la); send(0, nota_x);
    check("rewr_next_tipo", tipo, 2);
    check("rewr_wcnt2", word_cnt, 6);

    // asynchronous reset mid-word
    send(0, nota_do); send(0, nota_re);
    #3 reset = 1'b0;
    #1;
    check("async_fim", fim, 0);
    check("async_wcnt", word_cnt, 0);
    check("async_done", done, 0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    idle(1);
    check("post_rst_done", done, 0);
    check("post_rst_fim", fim, 0);
    // table was cleared: even the empty suffix no longer matches
    send(0, nota_do); send(0, nota_re); send(0, nota_x);
    check("cleared_tbl_err", err, 1);

    // idle timeout on the TIMEOUT=5 instance
    program_table();
    send(0, nota_do);
    idle(4);
    check("to_4_err", err_t, 0);
    idle(1);
    check("to_5_err", err_t, 1);
    check("to_5_done", done_t, 1);
    check("no_to_err", err, 0);
    check("no_to_fim", fim, 0);

    // word counter wrap
    pulse_reset();
    program_table();
    for (int i = 0; i < 255; i++) begin
      send(0, nota_do); send(0, nota_re); send(0, nota_x);
    end
    check("wcnt_255", word_cnt, 255);
    send(0, nota_do); send(0, nota_re); send(0, nota_x);
    check("wcnt_wrap", word_cnt, 0);
    check("wrap_tipo", tipo, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
